// File: rtl/z16_rf_write_sched.sv
// rtl/z16_rf_write_sched.sv - shares the register file write port between EX and LD
// writeback and tracks pending writes per register for decode hazard detection.
module z16_rf_write_sched #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_iss_valid,
  input  logic [ADDR_W-1:0] i_iss_rd_addr,
  output logic              o_iss_ready,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic              o_hazard,
  input  logic              i_ex_valid,
  input  logic [ADDR_W-1:0] i_ex_addr,
  input  logic [DATA_W-1:0] i_ex_data,
  output logic              o_ex_ready,
  input  logic              i_ld_valid,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_ld_ready,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_wen,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt [NREG];
  logic              pref_ex;
  logic              grant_ex;
  logic              grant_ld;
  logic              grant;
  logic              contended;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              iss_acc;
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_req;
  logic              underflow;

  // pref_ex names the source that wins the next contended cycle
  always_comb begin
    contended = i_ex_valid && i_ld_valid;
    grant_ex  = i_ex_valid && (!i_ld_valid || pref_ex);
    grant_ld  = i_ld_valid && !grant_ex;
    grant     = grant_ex || grant_ld;
    gnt_addr  = grant_ld ? i_ld_addr : i_ex_addr;
    gnt_data  = grant_ld ? i_ld_data : i_ex_data;
  end

  assign o_ex_ready  = grant_ex;
  assign o_ld_ready  = grant_ld;
  // a saturated counter still accepts when a writeback frees a slot this cycle
  assign o_iss_ready = (cnt[i_iss_rd_addr] != CNT_MAX) || (grant && (gnt_addr == i_iss_rd_addr));
  assign iss_acc     = i_iss_valid && o_iss_ready;

  assign o_hazard = (cnt[i_rs1_addr] != '0) || (cnt[i_rs2_addr] != '0) ||
                    (i_iss_valid && (cnt[i_iss_rd_addr] != '0));

  always_comb begin
    inc_vec   = '0;
    dec_req   = '0;
    underflow = 1'b0;
    for (int a = 1; a < NREG; a++) begin
      inc_vec[a] = iss_acc && (i_iss_rd_addr == ADDR_W'(a));
      dec_req[a] = grant && (gnt_addr == ADDR_W'(a));
      if (dec_req[a] && !inc_vec[a] && (cnt[a] == '0))
        underflow = 1'b1;
    end
  end

  // r0 is never incremented, so it stays at its reset value of zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int a = 0; a < NREG; a++)
        cnt[a] <= '0;
    end else begin
      for (int a = 1; a < NREG; a++) begin
        if (inc_vec[a] && !dec_req[a])
          cnt[a] <= cnt[a] + 1'b1;
        else if (dec_req[a] && !inc_vec[a] && (cnt[a] != '0))
          cnt[a] <= cnt[a] - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pref_ex   <= 1'b1;
      o_rd_wen  <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else begin
      if (contended)
        pref_ex <= !pref_ex;
      o_rd_wen <= grant && (gnt_addr != '0);
      if (grant) begin
        o_rd_addr <= gnt_addr;
        o_rd_data <= gnt_data;
      end
    end
  end

  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst) !underflow);

endmodule

// File: tb/tb_z16_rf_write_sched.sv
// tb/tb_z16_rf_write_sched.sv - directed and randomized checks of the write scheduler
// against a behavioural model of pending-write counts and round-robin arbitration.
module tb_z16_rf_write_sched;

  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid = 1'b0;
  logic [3:0]  iss_rd = '0;
  logic        iss_ready;
  logic [3:0]  rs1 = '0;
  logic [3:0]  rs2 = '0;
  logic        hazard;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_addr = '0;
  logic [15:0] ex_data = '0;
  logic        ex_ready;
  logic        ld_valid = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        ld_ready;
  logic [3:0]  rd_addr;
  logic        rd_wen;
  logic [15:0] rd_data;

  int n_pass = 0;
  int n_total = 0;

  z16_rf_write_sched dut (
    .i_clk(clk), .i_rst(rst),
    .i_iss_valid(iss_valid), .i_iss_rd_addr(iss_rd), .o_iss_ready(iss_ready),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2), .o_hazard(hazard),
    .i_ex_valid(ex_valid), .i_ex_addr(ex_addr), .i_ex_data(ex_data), .o_ex_ready(ex_ready),
    .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
    .o_rd_addr(rd_addr), .o_rd_wen(rd_wen), .o_rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Model: outstanding writes per register, who won the last contended cycle,
  // and the write currently presented to the register file.
  int        m_cnt [16];
  int        m_last_winner;   // 0 = EX, 1 = LD
  bit        m_wen;
  int        m_addr;
  int        m_data;
  bit        m_ex_took;
  bit        m_ld_took;
  int        claims [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void m_eval(output bit eg, output bit lg, output bit ir, output bit hz);
    int ga;
    eg = ex_valid && (!ld_valid || m_last_winner == 1);
    lg = ld_valid && !eg;
    ga = lg ? int'(ld_addr) : int'(ex_addr);
    ir = (m_cnt[iss_rd] < MAXC) || ((eg || lg) && ga == int'(iss_rd));
    hz = (m_cnt[rs1] > 0) || (m_cnt[rs2] > 0) || (iss_valid && m_cnt[iss_rd] > 0);
  endfunction

  always @(posedge clk or posedge rst) begin : model_upd
    bit eg, lg, ir, hz;
    int ga;
    int nc [16];
    if (rst) begin
      for (int a = 0; a < 16; a++) m_cnt[a] <= 0;
      m_last_winner <= 1;
      m_wen <= 1'b0;
      m_addr <= 0;
      m_data <= 0;
      m_ex_took <= 1'b0;
      m_ld_took <= 1'b0;
    end else begin
      m_eval(eg, lg, ir, hz);
      ga = lg ? int'(ld_addr) : int'(ex_addr);
      nc = m_cnt;
      if (iss_valid && ir && iss_rd != 0) nc[iss_rd] = nc[iss_rd] + 1;
      if ((eg || lg) && ga != 0 && nc[ga] > 0) nc[ga] = nc[ga] - 1;
      for (int a = 0; a < 16; a++) m_cnt[a] <= nc[a];
      if (ex_valid && ld_valid) m_last_winner <= eg ? 0 : 1;
      m_wen <= (eg || lg) && ga != 0;
      if (eg || lg) begin
        m_addr <= ga;
        m_data <= lg ? int'(ld_data) : int'(ex_data);
      end
      m_ex_took <= eg;
      m_ld_took <= lg;
    end
  end

  always @(negedge clk) begin : compare
    bit eg, lg, ir, hz;
    m_eval(eg, lg, ir, hz);
    check("ex_ready", 32'(ex_ready), 32'(eg));
    check("ld_ready", 32'(ld_ready), 32'(lg));
    check("iss_ready", 32'(iss_ready), 32'(ir));
    check("hazard", 32'(hazard), 32'(hz));
    check("rd_wen", 32'(rd_wen), 32'(m_wen));
    check("rd_addr", 32'(rd_addr), 32'(m_addr));
    check("rd_data", 32'(rd_data), 32'(m_data));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick();
    int s;
    int a;
    if ($urandom_range(7) == 0) return 0;
    s = $urandom_range(15);
    for (int k = 0; k < 16; k++) begin
      a = (s + k) % 16;
      if (a != 0 && m_cnt[a] - claims[a] > 0) return a;
    end
    return 0;
  endfunction

  initial begin
    int a;
    for (int i = 0; i < 16; i++) claims[i] = 0;

    // reset with EX request held, r7 issued on the release cycle
    ex_valid = 1'b1; ex_addr = 4'd7; ex_data = 16'hBEEF;
    repeat (3) begin
      @(negedge clk);
      check("rst_wen", 32'(rd_wen), 32'd0);
      check("rst_hazard", 32'(hazard), 32'd0);
    end
    step();
    rst = 1'b0; iss_valid = 1'b1; iss_rd = 4'd7;
    @(negedge clk);
    check("rel_ex_ready", 32'(ex_ready), 32'd1);
    step();
    ex_valid = 1'b0; iss_valid = 1'b0;
    @(negedge clk);
    check("rel_wen", 32'(rd_wen), 32'd1);
    check("rel_addr", 32'(rd_addr), 32'd7);
    check("rel_data", 32'(rd_data), 32'hBEEF);

    // r3 hazard cleared by its writeback
    step();
    iss_valid = 1'b1; iss_rd = 4'd3;
    step();
    iss_valid = 1'b0; rs1 = 4'd3;
    @(negedge clk);
    check("r3_hazard", 32'(hazard), 32'd1);
    step();
    ex_valid = 1'b1; ex_addr = 4'd3; ex_data = 16'h1234;
    @(negedge clk);
    check("r3_ex_ready", 32'(ex_ready), 32'd1);
    step();
    ex_valid = 1'b0;
    @(negedge clk);
    check("r3_hazard_clr", 32'(hazard), 32'd0);
    check("r3_wen", 32'(rd_wen), 32'd1);
    check("r3_addr", 32'(rd_addr), 32'd3);
    check("r3_data", 32'(rd_data), 32'h1234);
    step();
    rs1 = 4'd0;

    // contention alternates EX, LD, EX
    foreach (rs1[i]) begin end
    iss_valid = 1'b1; iss_rd = 4'd1; step(); step();
    iss_rd = 4'd2; step(); step();
    iss_valid = 1'b0;
    ex_valid = 1'b1; ex_addr = 4'd1; ex_data = 16'hAAAA;
    ld_valid = 1'b1; ld_addr = 4'd2; ld_data = 16'h5555;
    @(negedge clk);
    check("rr1_ex", 32'(ex_ready), 32'd1);
    check("rr1_ld", 32'(ld_ready), 32'd0);
    step();
    @(negedge clk);
    check("rr2_ld", 32'(ld_ready), 32'd1);
    check("rr2_addr", 32'(rd_addr), 32'd1);
    check("rr2_data", 32'(rd_data), 32'hAAAA);
    step();
    @(negedge clk);
    check("rr3_ex", 32'(ex_ready), 32'd1);
    check("rr3_addr", 32'(rd_addr), 32'd2);
    check("rr3_data", 32'(rd_data), 32'h5555);
    step();
    ex_valid = 1'b0;
    @(negedge clk);
    check("rr4_ld", 32'(ld_ready), 32'd1);
    check("rr4_addr", 32'(rd_addr), 32'd1);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    check("rr5_wen", 32'(rd_wen), 32'd1);
    check("rr5_addr", 32'(rd_addr), 32'd2);

    // saturation of r5 and simultaneous issue/writeback
    iss_valid = 1'b1; iss_rd = 4'd5;
    step(); step(); step();
    @(negedge clk);
    check("sat_iss_ready", 32'(iss_ready), 32'd0);
    step();
    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 16'h0505;
    @(negedge clk);
    check("sat_ld_ready", 32'(ld_ready), 32'd1);
    check("sat_iss_ok", 32'(iss_ready), 32'd1);
    step();
    iss_valid = 1'b0; ld_valid = 1'b0; rs1 = 4'd5;
    @(negedge clk);
    check("sat_still_full", 32'(iss_ready), 32'd0);
    check("sat_hazard", 32'(hazard), 32'd1);
    step();
    rs1 = 4'd0;

    // r0 writeback and issue
    ld_valid = 1'b1; ld_addr = 4'd0; ld_data = 16'hFFFF;
    @(negedge clk);
    check("r0_ld_ready", 32'(ld_ready), 32'd1);
    step();
    ld_valid = 1'b0; iss_valid = 1'b1; iss_rd = 4'd0;
    @(negedge clk);
    check("r0_wen", 32'(rd_wen), 32'd0);
    check("r0_iss_ready", 32'(iss_ready), 32'd1);
    check("r0_hazard", 32'(hazard), 32'd0);
    step();
    iss_valid = 1'b0;

    // asynchronous reset while a write is on the port
    iss_valid = 1'b1; iss_rd = 4'd9; step();
    iss_rd = 4'd10; step();
    iss_valid = 1'b0;
    ex_valid = 1'b1; ex_addr = 4'd9; ex_data = 16'h0909;
    step();
    ex_addr = 4'd10; ex_data = 16'h1010;
    #1;
    check("arst_pre_wen", 32'(rd_wen), 32'd1);
    #1;
    rst = 1'b1; ex_valid = 1'b0;
    #1;
    check("arst_wen_drop", 32'(rd_wen), 32'd0);
    step(); step();
    rst = 1'b0;
    for (int r = 0; r < 16; r++) begin
      rs1 = 4'(r); rs2 = 4'(r);
      @(negedge clk);
      check("arst_hazard", 32'(hazard), 32'd0);
      step();
    end

    // randomized traffic; requesters only target registers with unclaimed pending writes
    for (int c = 0; c < 3000; c++) begin
      if (ex_valid && m_ex_took) begin
        if (ex_addr != 0) claims[ex_addr]--;
        ex_valid = 1'b0;
      end
      if (ld_valid && m_ld_took) begin
        if (ld_addr != 0) claims[ld_addr]--;
        ld_valid = 1'b0;
      end
      if (!ex_valid && $urandom_range(1) == 1) begin
        a = pick();
        if (a != 0) claims[a]++;
        ex_valid = 1'b1; ex_addr = 4'(a); ex_data = 16'($urandom);
      end
      if (!ld_valid && $urandom_range(1) == 1) begin
        a = pick();
        if (a != 0) claims[a]++;
        ld_valid = 1'b1; ld_addr = 4'(a); ld_data = 16'($urandom);
      end
      iss_valid = 1'($urandom_range(1));
      iss_rd = 4'($urandom_range(15));
      rs1 = 4'($urandom_range(15));
      rs2 = 4'($urandom_range(15));
      step();
    end

    ex_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
